countdown_timer_ctrl: RTL and testbench

Sequences a cascade of three BCD down-counter digits (seconds units 9..0, seconds tens 5..0, minutes 9..0) that form the game's on-screen countdown clock. It generates the 1-second tick, presets the digits, and drives each digit's ena/ena_cnt for borrow propagation. It runs the start/pause/restart/expire state machine and stops the chain at 0:00 so the digits never wrap. It sits between the game-control logic and the digit counters feeding the VGA score/time drawer.

---
 rtl/countdown_timer_ctrl.sv | 134 +++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: sequencer for a 3-digit BCD countdown clock (M:SS).
// Generates the count tick, presets the digits, drives the borrow enables
// and runs the IDLE/LOAD/RUN/PAUSE/EXPIRED state machine.
// Ports:
//   clk, resetN               clock, async active-low reset
//   start, pause, restart     one-cycle control pulses from game control
//   tc_units/tens/min         digit-is-zero flags from the counters
//   tens_val                  current seconds-tens digit (for warn)
//   loadN, datain_*           parallel preset load to all digits
//   ena_tick, ena_cnt_*       count strobe and per-digit borrow enables
//   running, expired          status levels
//   expire_pulse, warn        expiry strobe and low-time warning
module countdown_timer_ctrl #(
  parameter int         TICK_DIV     = 25_000_000,
  parameter logic [3:0] PRESET_MIN   = 4'd2,
  parameter logic [3:0] PRESET_TENS  = 4'd0,
  parameter logic [3:0] PRESET_UNITS = 4'd0,
  parameter logic [3:0] WARN_TENS    = 4'd1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       pause,
  input  logic       restart,
  input  logic       tc_units,
  input  logic       tc_tens,
  input  logic       tc_min,
  input  logic [3:0] tens_val,
  output logic       loadN,
  output logic [3:0] datain_units,
  output logic [3:0] datain_tens,
  output logic [3:0] datain_min,
  output logic       ena_tick,
  output logic       ena_cnt_units,
  output logic       ena_cnt_tens,
  output logic       ena_cnt_min,
  output logic       running,
  output logic       expired,
  output logic       expire_pulse,
  output logic       warn
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_EXP   = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nx;
  logic          all_zero;
  logic          in_run;
  logic          at_last;

  assign datain_units = PRESET_UNITS;
  assign datain_tens  = PRESET_TENS;
  assign datain_min   = PRESET_MIN;

  assign all_zero = tc_units & tc_tens & tc_min;
  assign in_run   = (state == S_RUN);
  assign at_last  = (presc == LAST);

  // Digits only move on ena_tick, so 0:00 is always seen (and the
  // chain stopped) before another tick could wrap them.
  assign ena_tick      = in_run & at_last & ~all_zero;
  assign ena_cnt_units = in_run;
  assign ena_cnt_tens  = in_run & tc_units;
  assign ena_cnt_min   = in_run & tc_units & tc_tens;

  // restart beats everything; expiry beats pause while running.
  always_comb begin
    state_nx = state;
    if (restart) begin
      state_nx = S_LOAD;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nx = S_LOAD;
        S_LOAD:  state_nx = S_RUN;
        S_RUN: begin
          if (all_zero)   state_nx = S_EXP;
          else if (pause) state_nx = S_PAUSE;
        end
        S_PAUSE: if (pause) state_nx = S_RUN;
        S_EXP:   state_nx = S_EXP;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Prescaler runs in RUN, freezes in PAUSE, is cleared elsewhere.
  always_comb begin
    presc_nx = presc;
    case (state)
      S_RUN:   presc_nx = at_last ? '0 : presc + 1'b1;
      S_PAUSE: presc_nx = presc;
      default: presc_nx = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
      presc <= '0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
    end
  end

  // Status outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      loadN        <= 1'b1;
      running      <= 1'b0;
      expired      <= 1'b0;
      expire_pulse <= 1'b0;
      warn         <= 1'b0;
    end else begin
      loadN        <= (state_nx != S_LOAD);
      running      <= (state_nx == S_RUN);
      expired      <= (state_nx == S_EXP);
      expire_pulse <= (state_nx == S_EXP) & (state != S_EXP);
      warn         <= ((state == S_RUN) | (state == S_PAUSE))
                      & tc_min & (tens_val < WARN_TENS);
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: directed bench for countdown_timer_ctrl with
// external BCD digit counters and a seconds-level reference model.
module tb_countdown_timer_ctrl;

  localparam int TD       = 4;
  localparam int WARN     = 1;
  localparam int PRE_SECS = 72;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_EXP   = 4;

  logic       clk;
  logic       resetN;
  logic       start;
  logic       pause;
  logic       restart;
  logic       tc_units;
  logic       tc_tens;
  logic       tc_min;
  logic [3:0] tens_val;
  logic       loadN;
  logic [3:0] datain_units;
  logic [3:0] datain_tens;
  logic [3:0] datain_min;
  logic       ena_tick;
  logic       ena_cnt_units;
  logic       ena_cnt_tens;
  logic       ena_cnt_min;
  logic       running;
  logic       expired;
  logic       expire_pulse;
  logic       warn;

  countdown_timer_ctrl #(
    .TICK_DIV    (TD),
    .PRESET_MIN  (4'd1),
    .PRESET_TENS (4'd1),
    .PRESET_UNITS(4'd2),
    .WARN_TENS   (4'd1)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .start        (start),
    .pause        (pause),
    .restart      (restart),
    .tc_units     (tc_units),
    .tc_tens      (tc_tens),
    .tc_min       (tc_min),
    .tens_val     (tens_val),
    .loadN        (loadN),
    .datain_units (datain_units),
    .datain_tens  (datain_tens),
    .datain_min   (datain_min),
    .ena_tick     (ena_tick),
    .ena_cnt_units(ena_cnt_units),
    .ena_cnt_tens (ena_cnt_tens),
    .ena_cnt_min  (ena_cnt_min),
    .running      (running),
    .expired      (expired),
    .expire_pulse (expire_pulse),
    .warn         (warn)
  );

  always #5 clk = ~clk;

  int nchk;
  int nerr;
  bit chk_on;
  bit zero_ld;

  // External digit counters; zero_ld lets the bench load 0:00 instead.
  logic [3:0] d_u, d_t, d_m;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      d_u <= 0; d_t <= 0; d_m <= 0;
    end else if (!loadN) begin
      d_u <= zero_ld ? 4'd0 : datain_units;
      d_t <= zero_ld ? 4'd0 : datain_tens;
      d_m <= zero_ld ? 4'd0 : datain_min;
    end else if (ena_tick) begin
      if (ena_cnt_units) d_u <= (d_u == 0) ? 4'd9 : d_u - 1;
      if (ena_cnt_tens)  d_t <= (d_t == 0) ? 4'd5 : d_t - 1;
      if (ena_cnt_min)   d_m <= (d_m == 0) ? 4'd9 : d_m - 1;
    end
  end
  assign tc_units = (d_u == 0);
  assign tc_tens  = (d_t == 0);
  assign tc_min   = (d_m == 0);
  assign tens_val = d_t;

  // Reference model: mode, tick phase and remaining seconds.
  int m_st, m_ph, m_secs, m_ns;
  bit m_warn, m_xpf;
  bit e_tick;

  assign e_tick = (m_st == M_RUN) && (m_ph == TD - 1) && (m_secs != 0);

  always_comb begin
    m_ns = m_st;
    if (restart) m_ns = M_LOAD;
    else if (m_st == M_IDLE && start) m_ns = M_LOAD;
    else if (m_st == M_LOAD) m_ns = M_RUN;
    else if (m_st == M_RUN && m_secs == 0) m_ns = M_EXP;
    else if (m_st == M_RUN && pause) m_ns = M_PAUSE;
    else if (m_st == M_PAUSE && pause) m_ns = M_RUN;
  end

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_st <= M_IDLE; m_ph <= 0; m_secs <= 0;
      m_warn <= 0; m_xpf <= 0;
    end else begin
      if (m_st == M_LOAD) m_secs <= zero_ld ? 0 : PRE_SECS;
      else if (e_tick) m_secs <= m_secs - 1;
      if (m_st == M_RUN) m_ph <= (m_ph + 1) % TD;
      else if (m_st != M_PAUSE) m_ph <= 0;
      m_warn <= (m_st == M_RUN || m_st == M_PAUSE)
                && (m_secs < WARN * 10);
      m_xpf <= (m_ns == M_EXP) && (m_st != M_EXP);
      m_st <= m_ns;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("loadN", 8'(loadN), 8'(m_st != M_LOAD));
      chk("running", 8'(running), 8'(m_st == M_RUN));
      chk("expired", 8'(expired), 8'(m_st == M_EXP));
      chk("expire_pulse", 8'(expire_pulse), 8'(m_xpf));
      chk("warn", 8'(warn), 8'(m_warn));
      chk("ena_tick", 8'(ena_tick), 8'(e_tick));
      chk("ena_cnt_units", 8'(ena_cnt_units), 8'(m_st == M_RUN));
      chk("ena_cnt_tens", 8'(ena_cnt_tens),
          8'(m_st == M_RUN && m_secs % 10 == 0));
      chk("ena_cnt_min", 8'(ena_cnt_min),
          8'(m_st == M_RUN && m_secs % 60 == 0));
      chk("dig_min", 8'(d_m), 8'(m_secs / 60));
      chk("dig_tens", 8'(d_t), 8'((m_secs % 60) / 10));
      chk("dig_units", 8'(d_u), 8'(m_secs % 10));
      chk("datain", {datain_min, datain_units}, 8'h12);
    end
  end

  task automatic cyc(input bit s, input bit p, input bit r);
    start = s; pause = p; restart = r;
    @(posedge clk); #1;
    start = 0; pause = 0; restart = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc(0, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_loadN"}, 8'(loadN), 8'd1);
    chk({tag, "_tick"}, 8'(ena_tick), 8'd0);
    chk({tag, "_cnt"}, 8'({ena_cnt_units, ena_cnt_tens, ena_cnt_min}), 8'd0);
    chk({tag, "_running"}, 8'(running), 8'd0);
    chk({tag, "_expired"}, 8'(expired), 8'd0);
    chk({tag, "_xpulse"}, 8'(expire_pulse), 8'd0);
    chk({tag, "_warn"}, 8'(warn), 8'd0);
  endtask

  initial begin
    clk = 0; resetN = 1; start = 0; pause = 0; restart = 0;
    zero_ld = 0; chk_on = 0; nchk = 0; nerr = 0;
    #2 resetN = 0;
    #20 chk_reset_vals("rst");
    @(negedge clk) resetN = 1;
    chk_on = 1;
    @(posedge clk); #1;

    // pause in IDLE is ignored
    run(3);
    cyc(0, 1, 0);
    chk("idle_pause_ign", 8'(running), 8'd0);

    // start: one LOAD cycle, then RUN at 1:12, tick on 4th RUN cycle
    cyc(1, 0, 0);
    chk("load_low", 8'(loadN), 8'd0);
    run(1);
    chk("run_after_load", 8'(running), 8'd1);
    chk("preset_digits", {d_t, d_u}, 8'h12);
    run(3);
    chk("first_tick", 8'(ena_tick), 8'd1);
    run(1);
    chk("after_tick", {d_t, d_u}, 8'h11);

    // 1:00 -> 0:59 borrow into minutes
    run(47);
    chk("min_borrow_tick", 8'(ena_tick), 8'd1);
    chk("min_borrow_en", 8'({ena_cnt_tens, ena_cnt_min}), 8'b11);
    run(1);
    chk("dig_059", {d_m, d_t}, 8'h05);
    chk("dig_059_u", 8'(d_u), 8'd9);

    // pause mid-period, hold 20 cycles, resume
    run(1);
    cyc(0, 1, 0);
    chk("paused", 8'(running), 8'd0);
    run(20);
    chk("pause_no_tick", 8'(ena_tick), 8'd0);
    chk("pause_digits", {d_t, d_u}, 8'h59);
    cyc(0, 1, 0);
    chk("resumed", 8'(running), 8'd1);
    run(1);
    chk("resume_tick", 8'(ena_tick), 8'd1);
    // pause on a tick cycle: the tick still lands
    cyc(0, 1, 0);
    chk("tick_pause_dig", {d_t, d_u}, 8'h58);
    chk("tick_pause_st", 8'(running), 8'd0);
    cyc(0, 1, 0);

    // start is ignored while running
    cyc(1, 0, 0);
    chk("start_ign", 8'(loadN), 8'd1);
    run(191);
    chk("warn_010", 8'(warn), 8'd0);
    run(3);
    chk("tens_borrow", 8'({ena_tick, ena_cnt_tens}), 8'b11);
    run(1);
    chk("dig_009", {d_t, d_u}, 8'h09);
    chk("warn_lag", 8'(warn), 8'd0);
    run(1);
    chk("warn_on", 8'(warn), 8'd1);

    // run out to 0:00 and expire
    run(35);
    chk("zero_no_tick", 8'(ena_tick), 8'd0);
    run(1);
    chk("exp_pulse", 8'({expired, expire_pulse}), 8'b11);
    run(1);
    chk("exp_pulse_once", 8'({expired, expire_pulse}), 8'b10);
    chk("exp_warn_off", 8'(warn), 8'd0);
    run(10);

    // restart from EXPIRED, then mid-RUN, then from LOAD
    cyc(0, 0, 1);
    chk("rs_exp_load", 8'({loadN, expired}), 8'b00);
    run(1);
    chk("rs_exp_dig", {d_t, d_u}, 8'h12);
    run(6);
    cyc(0, 0, 1);
    chk("rs_run_load", 8'(loadN), 8'd0);
    run(3);
    cyc(1, 1, 1);
    chk("rs_all_load", 8'(loadN), 8'd0);
    cyc(0, 0, 1);
    chk("rs_in_load", 8'(loadN), 8'd0);
    run(1);
    chk("rs_in_load_run", 8'(running), 8'd1);
    run(5);

    // 0:00 preset: one RUN cycle, then EXPIRED, never a tick
    zero_ld = 1;
    cyc(0, 0, 1);
    run(1);
    zero_ld = 0;
    chk("z_run", 8'({running, ena_tick}), 8'b10);
    run(1);
    chk("z_exp", 8'({expired, expire_pulse}), 8'b11);
    run(3);

    // async reset mid-run
    cyc(0, 0, 1);
    run(10);
    #3 resetN = 0;
    #1 chk_reset_vals("arst");
    @(negedge clk);
    @(negedge clk) resetN = 1;
    @(posedge clk); #1;
    run(3);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
